uart_rx_fifo: RTL

Parametrised UART receiver for the peripheral subsystem.
- Recovers frames from `rx_i` with a two-flop synchroniser, mid-bit sampling and false-start rejection.
- Frame format: configurable data width and optional parity.
- Each received word goes into a first-word-fall-through FIFO together with its frame-error, parity-error and break status.
- The bus-side register block reads the FIFO head and the sticky overrun flag directly.

---
 rtl/uart_rx_fifo.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// UART receiver with start-bit validation, optional parity and a
// first-word-fall-through status FIFO.
module uart_rx_fifo #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 32,
    parameter int PARITY_EN = 0
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [15:0]              baud_div_i,
    input  logic                     parity_odd_i,
    input  logic                     en_i,
    input  logic                     re_i,
    input  logic                     clr_i,
    input  logic                     rx_i,
    output logic [DATA_W-1:0]        data_o,
    output logic                     frame_err_o,
    output logic                     parity_err_o,
    output logic                     break_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     overrun_o,
    output logic                     busy_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int BW = $clog2(DATA_W);
    localparam int EW = DATA_W + 3;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);
    localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT
    } state_t;

    logic              r_sync1, r_sync2, r_rx_d;
    logic              w_rx_s;
    state_t            r_state, w_state_nx;
    logic [15:0]       r_cnt;
    logic [BW-1:0]     r_bit;
    logic [DATA_W-1:0] r_shift;
    logic              r_par;
    logic              r_busy;

    logic w_fall, w_half, w_hit;
    logic w_cnt_clr, w_smp_data, w_smp_par, w_push;
    logic w_ferr, w_perr, w_brk;
    logic [EW-1:0] w_entry;

    assign w_rx_s = r_sync2;
    assign w_fall = r_rx_d & ~w_rx_s;
    assign w_half = (r_cnt == (baud_div_i >> 1));
    assign w_hit  = (r_cnt == baud_div_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_rx_d  <= 1'b1;
        end else begin
            r_sync1 <= rx_i;
            r_sync2 <= r_sync1;
            r_rx_d  <= r_sync2;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_cnt_clr  = 1'b0;
        w_smp_data = 1'b0;
        w_smp_par  = 1'b0;
        w_push     = 1'b0;
        if (!en_i) begin
            w_state_nx = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE: if (w_fall) begin
                    w_state_nx = S_START;
                    w_cnt_clr  = 1'b1;
                end
                S_START: if (w_half) begin
                    w_cnt_clr  = 1'b1;
                    w_state_nx = w_rx_s ? S_IDLE : S_DATA;
                end
                S_DATA: if (w_hit) begin
                    w_cnt_clr  = 1'b1;
                    w_smp_data = 1'b1;
                    if (r_bit == LAST_BIT)
                        w_state_nx = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                end
                S_PARITY: if (w_hit) begin
                    w_cnt_clr  = 1'b1;
                    w_smp_par  = 1'b1;
                    w_state_nx = S_STOP;
                end
                S_STOP: if (w_hit) begin
                    w_cnt_clr  = 1'b1;
                    w_push     = 1'b1;
                    w_state_nx = w_rx_s ? S_IDLE : S_WAIT;
                end
                S_WAIT: if (w_rx_s) w_state_nx = S_IDLE;
                default: w_state_nx = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_busy  <= (w_state_nx != S_IDLE);
            if (w_cnt_clr || r_state == S_IDLE)
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + 16'd1;
            if (r_state == S_START)
                r_bit <= '0;
            else if (w_smp_data)
                r_bit <= r_bit + 1'b1;
            if (w_smp_data)
                r_shift <= {w_rx_s, r_shift[DATA_W-1:1]};
            if (w_smp_par)
                r_par <= w_rx_s;
        end
    end

    assign w_ferr  = ~w_rx_s;
    assign w_perr  = (PARITY_EN != 0) &&
                     ((^r_shift ^ r_par) != parity_odd_i);
    assign w_brk   = w_ferr && (r_shift == '0) &&
                     ((PARITY_EN == 0) || !r_par);
    assign w_entry = {w_brk, w_perr, w_ferr, r_shift};

    // FIFO: level-based full so every slot is usable
    logic [EW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [AW:0]   r_level;
    logic          r_ovr;
    logic          w_empty, w_full, w_pop, w_wr, w_ovf;
    logic [EW-1:0] w_head;

    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == FULL_LVL);
    assign w_pop   = re_i & ~w_empty;
    assign w_wr    = w_push & (~w_full | w_pop);
    assign w_ovf   = w_push & w_full & ~re_i;

    always_ff @(posedge clk_i) begin
        if (w_wr)
            r_mem[r_wptr] <= w_entry;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_ovr   <= 1'b0;
        end else begin
            if (w_wr)
                r_wptr <= r_wptr + 1'b1;
            if (w_pop)
                r_rptr <= r_rptr + 1'b1;
            case ({w_wr, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
            r_ovr <= w_ovf | (r_ovr & ~clr_i);
        end
    end

    assign w_head       = r_mem[r_rptr];
    assign data_o       = w_empty ? '0 : w_head[DATA_W-1:0];
    assign frame_err_o  = ~w_empty & w_head[DATA_W];
    assign parity_err_o = ~w_empty & w_head[DATA_W+1];
    assign break_o      = ~w_empty & w_head[DATA_W+2];
    assign empty_o      = w_empty;
    assign full_o       = w_full;
    assign level_o      = r_level;
    assign overrun_o    = r_ovr;
    assign busy_o       = r_busy;

endmodule
